sipo_deframer: RTL

- Serial-in/parallel-out receive stage. Sits directly downstream of the team's 4-bit PISO shifter and reassembles its serial stream into parallel words.
- Frame start is marked by `sof`, aligned with the PISO `load` strobe.
- Completed words are held in a one-entry output register with a valid/ready handshake toward the consumer.
- Frame-abort and overrun conditions are flagged as single-cycle pulses.

---
 rtl/sipo_deframer_pkg.sv | 12 +
 rtl/sipo_deframer_if.sv | 25 ++
 rtl/sipo_out_reg.sv | 48 ++++
 rtl/sipo_deframer.sv | 94 +++++++++
 4 files changed

// File: rtl/sipo_deframer_pkg.sv
// Shared definitions for the SIPO deframer and its upstream PISO partner.
// Both ends take their word width and state encoding from here.
package sipo_deframer_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/sipo_deframer_if.sv
// Serial-in / parallel-out bundle: the serial bit stream in, the held word out.
// The master side is the producer/consumer environment, the slave side is the deframer.
interface sipo_deframer_if #(parameter int WIDTH = sipo_deframer_pkg::DEFAULT_WIDTH);

  logic             din;
  logic             bit_vld;
  logic             sof;
  logic             out_rdy;
  logic [WIDTH-1:0] dout;
  logic             out_vld;
  logic             busy;
  logic             frame_err;
  logic             ovf;

  modport master (
    output din, bit_vld, sof, out_rdy,
    input  dout, out_vld, busy, frame_err, ovf
  );

  modport slave (
    input  din, bit_vld, sof, out_rdy,
    output dout, out_vld, busy, frame_err, ovf
  );

endinterface

// File: rtl/sipo_out_reg.sv
// One-entry valid/ready holding register for completed words.
// A word arriving while the entry is full and not being popped is dropped and flagged.
module sipo_out_reg #(
  parameter int WIDTH = sipo_deframer_pkg::DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             res,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_word,
  input  logic             i_rdy,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_vld,
  output logic             o_ovf
);

  logic [WIDTH-1:0] r_dout;
  logic             r_vld;
  logic             r_ovf;
  logic             w_pop;

  assign w_pop = r_vld & i_rdy;

  // A pop in the same cycle frees the slot, so a completing word may replace it.
  always_ff @(posedge clk) begin
    if (res) begin
      r_dout <= '0;
      r_vld  <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_ovf <= 1'b0;
      if (i_wr) begin
        if (!r_vld || w_pop) begin
          r_dout <= i_word;
          r_vld  <= 1'b1;
        end else begin
          r_ovf <= 1'b1;
        end
      end else if (w_pop) begin
        r_vld <= 1'b0;
      end
    end
  end

  assign o_dout = r_dout;
  assign o_vld  = r_vld;
  assign o_ovf  = r_ovf;

endmodule

// File: rtl/sipo_deframer.sv
// Reassembles the PISO serial stream into WIDTH-bit words, framed by sof.
// The shift/count FSM lives here; completed words go to the holding register.
module sipo_deframer
  import sipo_deframer_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic            clk,
  input  logic            res,
  sipo_deframer_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_sr;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_ferr;

  logic             w_start;
  logic             w_accept;
  logic             w_complete;
  logic [WIDTH-1:0] w_shifted;
  logic [CW-1:0]    w_cnt_next;
  logic [WIDTH-1:0] w_dout;
  logic             w_vld;
  logic             w_ovf;

  // Loop form keeps the shift legal for WIDTH=1, where the slice would be empty.
  function automatic logic [WIDTH-1:0] shiftIn(input logic [WIDTH-1:0] sr, input logic b);
    logic [WIDTH-1:0] v;
    v = '0;
    if (MSB_FIRST) begin
      v[0] = b;
      for (int i = 1; i < WIDTH; i++) v[i] = sr[i-1];
    end else begin
      v[WIDTH-1] = b;
      for (int i = 0; i < WIDTH - 1; i++) v[i] = sr[i+1];
    end
    return v;
  endfunction

  always_comb begin
    w_start    = bus.bit_vld & bus.sof;
    w_accept   = bus.bit_vld & (bus.sof | (r_state == SHIFT));
    w_shifted  = shiftIn(w_start ? '0 : r_sr, bus.din);
    w_cnt_next = w_start ? CW'(1) : r_cnt + CW'(1);
    w_complete = w_accept && (w_cnt_next == CW'(WIDTH));
  end

  always_ff @(posedge clk) begin
    if (res) begin
      r_state <= IDLE;
      r_sr    <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_ferr <= w_start && (r_state == SHIFT);
      if (w_accept) begin
        r_sr <= w_shifted;
        if (w_complete) begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
        end else begin
          r_state <= SHIFT;
          r_cnt   <= w_cnt_next;
          r_busy  <= 1'b1;
        end
      end
    end
  end

  sipo_out_reg #(.WIDTH(WIDTH)) u_out_reg (
    .clk    (clk),
    .res    (res),
    .i_wr   (w_complete),
    .i_word (w_shifted),
    .i_rdy  (bus.out_rdy),
    .o_dout (w_dout),
    .o_vld  (w_vld),
    .o_ovf  (w_ovf)
  );

  assign bus.dout      = w_dout;
  assign bus.out_vld   = w_vld;
  assign bus.ovf       = w_ovf;
  assign bus.busy      = r_busy;
  assign bus.frame_err = r_ferr;

endmodule
